// File: rtl/bicantor_pkg.sv
// Shared types and constants for the fetch/decode front end.
//   INSN_W / PACKET_W : instruction and fetch-packet widths
//   ADDR_MAX_W        : widest packet address any user may configure
//   SLOT0/SLOT1/BOTH  : per-slot valid mask encodings (bit0 = older slot)
//   fetch_packet_t    : one queue entry {data, addr, mask}
package bicantor_pkg;

   localparam int INSN_W     = 32;
   localparam int PACKET_W   = 2 * INSN_W;
   localparam int ADDR_MAX_W = 32;

   localparam logic [1:0] SLOT0 = 2'b01;
   localparam logic [1:0] SLOT1 = 2'b10;
   localparam logic [1:0] BOTH  = 2'b11;

   // The address field is sized for the widest configuration. Narrower
   // instances zero-extend on write and slice on read.
   typedef struct packed {
      logic [PACKET_W-1:0]   data;
      logic [ADDR_MAX_W-1:0] addr;
      logic [1:0]            mask;
   } fetch_packet_t;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: circular buffer of fetch packets between instruction memory
// and the dual-issue decoder.
//   clock_i, resetn_i          : clock, async active-low reset
//   flush_i                    : redirect, empties the queue on the next edge
//   enq_valid_i/data/addr/mask : packet from memory (mask 2'b00 is dropped)
//   enq_ready_o, imemstall_o   : not-full, and its inverse to hold the read
//   deq_valid_o/data/addr/mask : head entry, mask shows unconsumed slots
//   deq_take_i                 : slots the decoder consumes this cycle
//   count_o                    : occupancy
module fetch_queue
   import bicantor_pkg::*;
#(
   parameter  int DEPTH  = 4,
   parameter  int ADDR_W = 10,
   localparam int CNT_W  = $clog2(DEPTH + 1),
   localparam int PTR_W  = $clog2(DEPTH)
) (
   input  logic                clock_i,
   input  logic                resetn_i,
   input  logic                flush_i,
   input  logic                enq_valid_i,
   input  logic [PACKET_W-1:0] enq_data_i,
   input  logic [ADDR_W-1:0]   enq_addr_i,
   input  logic [1:0]          enq_mask_i,
   output logic                enq_ready_o,
   output logic                imemstall_o,
   output logic                deq_valid_o,
   output logic [PACKET_W-1:0] deq_data_o,
   output logic [ADDR_W-1:0]   deq_addr_o,
   output logic [1:0]          deq_mask_o,
   input  logic [1:0]          deq_take_i,
   output logic [CNT_W-1:0]    count_o
);

   fetch_packet_t    mem [DEPTH];
   logic [PTR_W-1:0] head, tail;
   logic [CNT_W-1:0] count;

   fetch_packet_t    head_ent;
   fetch_packet_t    enq_ent;
   logic             take_legal, take_fire, pop, enq_fire;
   logic [1:0]       new_mask;

   assign head_ent = mem[head];

   always_comb begin
      enq_ent      = '0;
      enq_ent.data = enq_data_i;
      enq_ent.addr[ADDR_W-1:0] = enq_addr_i;
      enq_ent.mask = enq_mask_i;
   end

   // Ready looks only at registered occupancy so a full queue never
   // accepts, even in a cycle where it also pops.
   assign enq_ready_o = (count < CNT_W'(DEPTH));
   assign imemstall_o = ~enq_ready_o;
   assign deq_valid_o = (count != '0);
   assign deq_data_o  = head_ent.data;
   assign deq_addr_o  = head_ent.addr[ADDR_W-1:0];
   assign deq_mask_o  = deq_valid_o ? head_ent.mask : 2'b00;
   assign count_o     = count;

   // Takes must be a subset of the remaining slots and keep program order:
   // slot 1 alone is refused while slot 0 is still pending.
   assign take_legal = deq_valid_o
                     && ((deq_take_i & ~deq_mask_o) == 2'b00)
                     && !(deq_take_i == SLOT1 && deq_mask_o == BOTH);
   assign take_fire  = take_legal && (deq_take_i != 2'b00);
   assign new_mask   = deq_mask_o & ~deq_take_i;
   assign pop        = take_fire && (new_mask == 2'b00);
   assign enq_fire   = enq_valid_i && enq_ready_o && !flush_i
                     && (enq_mask_i != 2'b00);

   // Upper address bits are always zero in narrow configurations.
   logic unused_addr_hi;
   assign unused_addr_hi = ^head_ent.addr;

   always_ff @(posedge clock_i or negedge resetn_i) begin
      if (!resetn_i) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush_i) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i].mask <= 2'b00;
      end else begin
         // head == tail only when empty (no take) or full (no enqueue),
         // so the two writes below never hit the same entry.
         if (take_fire) mem[head].mask <= new_mask;
         if (pop)       head <= head + 1'b1;
         if (enq_fire) begin
            mem[tail] <= enq_ent;
            tail      <= tail + 1'b1;
         end
         if (enq_fire && !pop)      count <= count + 1'b1;
         else if (!enq_fire && pop) count <= count - 1'b1;
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge clock_i) begin
      if (resetn_i && !flush_i && deq_take_i != 2'b00)
         assert (take_legal)
         else $warning("fetch_queue: illegal take %b on mask %b ignored",
                       deq_take_i, deq_mask_o);
   end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset, fill, partial take, simultaneous
// enqueue/pop, flush, and wrap with a dropped zero-mask packet.
module tb_fetch_queue;
   import bicantor_pkg::*;

   localparam int DEPTH  = 4;
   localparam int ADDR_W = 10;
   localparam int CNT_W  = $clog2(DEPTH + 1);

   logic                clock_i = 1'b0;
   logic                resetn_i;
   logic                flush_i;
   logic                enq_valid_i;
   logic [PACKET_W-1:0] enq_data_i;
   logic [ADDR_W-1:0]   enq_addr_i;
   logic [1:0]          enq_mask_i;
   logic                enq_ready_o;
   logic                imemstall_o;
   logic                deq_valid_o;
   logic [PACKET_W-1:0] deq_data_o;
   logic [ADDR_W-1:0]   deq_addr_o;
   logic [1:0]          deq_mask_o;
   logic [1:0]          deq_take_i;
   logic [CNT_W-1:0]    count_o;

   int checks = 0;
   int errors = 0;

   fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clock_i(clock_i), .resetn_i(resetn_i), .flush_i(flush_i),
      .enq_valid_i(enq_valid_i), .enq_data_i(enq_data_i),
      .enq_addr_i(enq_addr_i), .enq_mask_i(enq_mask_i),
      .enq_ready_o(enq_ready_o), .imemstall_o(imemstall_o),
      .deq_valid_o(deq_valid_o), .deq_data_o(deq_data_o),
      .deq_addr_o(deq_addr_o), .deq_mask_o(deq_mask_o),
      .deq_take_i(deq_take_i), .count_o(count_o)
   );

   always #5 clock_i = ~clock_i;

   function automatic logic [PACKET_W-1:0] pkt_data(input logic [ADDR_W-1:0] a);
      return {22'h0ab, a, 22'h155, a};
   endfunction

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic step();
      @(posedge clock_i);
      #1;
   endtask

   task automatic drive(input logic v, input int a, input logic [1:0] m,
                        input logic [1:0] take);
      enq_valid_i = v;
      enq_addr_i  = ADDR_W'(a);
      enq_data_i  = pkt_data(ADDR_W'(a));
      enq_mask_i  = m;
      deq_take_i  = take;
   endtask

   task automatic idle();
      drive(1'b0, 0, 2'b00, 2'b00);
      flush_i = 1'b0;
   endtask

   task automatic clear();
      idle();
      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
   endtask

   task automatic test_reset();
      resetn_i = 1'b0;
      idle();
      #12;
      checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", count_o); end
      checks++; if (deq_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", deq_valid_o); end
      checks++; if (deq_mask_o !== 2'b00) begin errors++; $display("FAIL rst_mask got %b exp 00", deq_mask_o); end
      checks++; if (enq_ready_o !== 1'b1 || imemstall_o !== 1'b0) begin errors++; $display("FAIL rst_ready got %b/%b exp 1/0", enq_ready_o, imemstall_o); end
      checks++; if (deq_data_o !== 64'h0 || deq_addr_o !== 10'h0) begin errors++; $display("FAIL rst_storage got %h/%h exp 0/0", deq_data_o, deq_addr_o); end
      resetn_i = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         drive(1'b1, i, BOTH, 2'b00);
         step();
      end
      idle();
      checks++; if (count_o !== 3'd3) begin errors++; $display("FAIL pre_rst_count got %0d exp 3", count_o); end
      // Asynchronous reset in the middle of a cycle, with entries held.
      #2 resetn_i = 1'b0;
      #1;
      checks++; if (count_o !== 3'd0 || deq_valid_o !== 1'b0 || enq_ready_o !== 1'b1) begin errors++; $display("FAIL mid_rst got cnt=%0d v=%b r=%b exp 0/0/1", count_o, deq_valid_o, enq_ready_o); end
      @(negedge clock_i);
      resetn_i = 1'b1;
      drive(1'b1, 9, BOTH, 2'b00);
      #1;
      checks++; if (deq_valid_o !== 1'b0) begin errors++; $display("FAIL no_bypass got %b exp 0", deq_valid_o); end
      step();
      idle();
      checks++; if (deq_valid_o !== 1'b1 || deq_addr_o !== 10'd9 || count_o !== 3'd1) begin errors++; $display("FAIL post_rst_enq got v=%b a=%0d c=%0d exp 1/9/1", deq_valid_o, deq_addr_o, count_o); end
      checks++; if (deq_data_o !== pkt_data(10'd9)) begin errors++; $display("FAIL post_rst_data got %h exp %h", deq_data_o, pkt_data(10'd9)); end
   endtask

   task automatic test_fill();
      clear();
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, i, BOTH, 2'b00);
         step();
      end
      idle();
      checks++; if (count_o !== 3'd4) begin errors++; $display("FAIL fill_count got %0d exp 4", count_o); end
      checks++; if (imemstall_o !== 1'b1 || enq_ready_o !== 1'b0) begin errors++; $display("FAIL fill_stall got %b/%b exp 1/0", imemstall_o, enq_ready_o); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (deq_addr_o !== ADDR_W'(i)) begin errors++; $display("FAIL fill_order got %0d exp %0d", deq_addr_o, i); end
         deq_take_i = BOTH;
         step();
         if (i == 0) begin
            checks++; if (imemstall_o !== 1'b0) begin errors++; $display("FAIL stall_fall got %b exp 0", imemstall_o); end
         end
      end
      idle();
      checks++; if (count_o !== 3'd0 || deq_valid_o !== 1'b0) begin errors++; $display("FAIL fill_drain got c=%0d v=%b exp 0/0 (addr 4 stored?)", count_o, deq_valid_o); end
   endtask

   task automatic test_partial_take();
      clear();
      drive(1'b1, 7, BOTH, 2'b00);
      step();
      drive(1'b0, 0, 2'b00, SLOT0);
      step();
      checks++; if (deq_mask_o !== SLOT1 || deq_addr_o !== 10'd7 || count_o !== 3'd1) begin errors++; $display("FAIL part_slot0 got m=%b a=%0d c=%0d exp 10/7/1", deq_mask_o, deq_addr_o, count_o); end
      deq_take_i = SLOT1;
      step();
      checks++; if (count_o !== 3'd0 || deq_valid_o !== 1'b0) begin errors++; $display("FAIL part_pop got c=%0d v=%b exp 0/0", count_o, deq_valid_o); end
      drive(1'b1, 8, BOTH, 2'b00);
      step();
      drive(1'b0, 0, 2'b00, SLOT1);
      step();
      checks++; if (deq_mask_o !== BOTH || count_o !== 3'd1 || deq_addr_o !== 10'd8) begin errors++; $display("FAIL illegal_take got m=%b c=%0d a=%0d exp 11/1/8", deq_mask_o, count_o, deq_addr_o); end
      idle();
   endtask

   task automatic test_simultaneous();
      clear();
      drive(1'b1, 20, BOTH, 2'b00); step();
      drive(1'b1, 21, BOTH, 2'b00); step();
      drive(1'b1, 22, BOTH, BOTH);  step();
      checks++; if (count_o !== 3'd2 || deq_addr_o !== 10'd21) begin errors++; $display("FAIL simul_mid got c=%0d a=%0d exp 2/21", count_o, deq_addr_o); end
      drive(1'b1, 23, BOTH, 2'b00); step();
      drive(1'b1, 24, BOTH, 2'b00); step();
      drive(1'b1, 25, BOTH, BOTH);  step();
      checks++; if (count_o !== 3'd3 || deq_addr_o !== 10'd22) begin errors++; $display("FAIL simul_full got c=%0d a=%0d exp 3/22", count_o, deq_addr_o); end
      for (int i = 22; i <= 24; i++) begin
         checks++; if (deq_addr_o !== ADDR_W'(i)) begin errors++; $display("FAIL simul_drain got %0d exp %0d", deq_addr_o, i); end
         drive(1'b0, 0, 2'b00, BOTH);
         step();
      end
      idle();
      checks++; if (deq_valid_o !== 1'b0) begin errors++; $display("FAIL simul_empty got %b exp 0", deq_valid_o); end
   endtask

   task automatic test_flush();
      clear();
      for (int i = 30; i < 33; i++) begin
         drive(1'b1, i, BOTH, 2'b00);
         step();
      end
      drive(1'b1, 40, BOTH, BOTH);
      flush_i = 1'b1;
      step();
      idle();
      checks++; if (count_o !== 3'd0 || deq_valid_o !== 1'b0 || deq_mask_o !== 2'b00 || enq_ready_o !== 1'b1) begin errors++; $display("FAIL flush got c=%0d v=%b m=%b r=%b exp 0/0/00/1", count_o, deq_valid_o, deq_mask_o, enq_ready_o); end
      step();
      checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL flush_lost got %0d exp 0", count_o); end
   endtask

   task automatic test_wrap_drop();
      int exp_q[$];
      logic [1:0] m;
      clear();
      drive(1'b1, 50, BOTH, 2'b00);
      step();
      exp_q.push_back(50);
      for (int i = 0; i < 10; i++) begin
         m = (i == 4) ? 2'b00 : BOTH;
         if (exp_q.size() != 0) begin
            checks++; if (deq_addr_o !== ADDR_W'(exp_q[0]) || deq_mask_o !== BOTH) begin errors++; $display("FAIL wrap_head got a=%0d m=%b exp %0d/11", deq_addr_o, deq_mask_o, exp_q[0]); end
            drive(1'b1, 51 + i, m, BOTH);
            void'(exp_q.pop_front());
         end else begin
            drive(1'b1, 51 + i, m, 2'b00);
         end
         step();
         if (m != 2'b00) exp_q.push_back(51 + i);
         checks++; if (count_o !== CNT_W'(exp_q.size())) begin errors++; $display("FAIL wrap_count got %0d exp %0d", count_o, exp_q.size()); end
      end
      idle();
   endtask

   initial begin
      flush_i = 1'b0;
      test_reset();
      test_fill();
      test_partial_take();
      test_simultaneous();
      test_flush();
      test_wrap_drop();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
